// File: rtl/xcvr_seq_pkg.sv
// Shared definitions for the transceiver link sequencer: state encoding,
// default timing parameters, status bundle layout and small helpers.
package xcvr_seq_pkg;

    localparam int unsigned ST_W    = 3;
    localparam int unsigned TIMER_W = 32;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned STAT_W  = 16;
    localparam int unsigned SYNC_W  = 7;

    localparam int unsigned DEF_RST_HOLD      = 64;
    localparam int unsigned DEF_LTR_DWELL     = 5000;
    localparam int unsigned DEF_TIMEOUT       = 1000000;
    localparam int unsigned DEF_MAX_RETRY     = 4;
    localparam int unsigned DEF_LOSS_DEBOUNCE = 16;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_RESET    = 3'd1,
        ST_WAIT_CAL = 3'd2,
        ST_LTR      = 3'd3,
        ST_LTD      = 3'd4,
        ST_UP       = 3'd5,
        ST_FAIL     = 3'd6
    } seq_state_e;

    // Status inputs as seen after the synchroniser; first field is the MSB.
    typedef struct packed {
        logic lockedtodata;
        logic lockedtoref;
        logic reconfig_busy;
        logic rx_cal_busy;
        logic tx_cal_busy;
        logic rx_ready;
        logic tx_ready;
    } xcvr_status_t;

    function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
        return (v == '1) ? v : v + RETRY_W'(1);
    endfunction

endpackage

// File: rtl/xcvr_sync2.sv
// Two-flop synchroniser for quasi-static status bits crossing into CLK.
module xcvr_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/xcvr_link_sequencer.sv
// Bring-up and recovery sequencer for one transceiver channel (reset, cal wait,
// CDR LTR->LTD walk, lock-loss monitor, bounded retry). XCVR_SEQ_STATS_EN adds lock_loss_cnt.
module xcvr_link_sequencer
    import xcvr_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD      = DEF_RST_HOLD,
    parameter int unsigned LTR_DWELL     = DEF_LTR_DWELL,
    parameter int unsigned TIMEOUT       = DEF_TIMEOUT,
    parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY,
    parameter int unsigned LOSS_DEBOUNCE = DEF_LOSS_DEBOUNCE
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               start,
    input  logic               tx_ready,
    input  logic               rx_ready,
    input  logic               tx_cal_busy,
    input  logic               rx_cal_busy,
    input  logic               reconfig_busy,
    input  logic               rx_is_lockedtoref,
    input  logic               rx_is_lockedtodata,
    output logic               xcvr_reset,
    output logic               rx_set_locktoref,
    output logic               rx_set_locktodata,
    output logic               link_up,
    output logic               link_fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [ST_W-1:0]    seq_state
`ifdef XCVR_SEQ_STATS_EN
    ,
    output logic [STAT_W-1:0]  lock_loss_cnt
`endif
);

    localparam int unsigned DWELL_W = $clog2(LTR_DWELL + 1);
    localparam int unsigned LOSS_W  = $clog2(LOSS_DEBOUNCE + 1);

    xcvr_status_t status_raw;
    xcvr_status_t status_s;

    seq_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic [RETRY_W-1:0] retry_q, retry_d;

    logic xcvr_reset_q, xcvr_reset_d;
    logic ltr_q, ltr_d;
    logic ltd_q, ltd_d;
    logic link_up_q, link_up_d;
    logic link_fail_q, link_fail_d;

    logic timed_out;
    logic cal_done;
    logic attempt_fail;

    assign status_raw = {rx_is_lockedtodata, rx_is_lockedtoref, reconfig_busy,
                         rx_cal_busy, tx_cal_busy, rx_ready, tx_ready};

    xcvr_sync2 #(
        .WIDTH (SYNC_W)
    ) u_status_sync (
        .CLK  (CLK),
        .nRST (nRST),
        .d_i  (status_raw),
        .q_o  (status_s)
    );

    assign timed_out = (timer_q == TIMER_W'(TIMEOUT - 1));
    assign cal_done  = !status_s.tx_cal_busy && !status_s.rx_cal_busy &&
                       !status_s.reconfig_busy && status_s.tx_ready;

    // Next-state and next-output decode; outputs follow the state being entered.
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        dwell_d      = '0;
        loss_d       = '0;
        attempt_fail = 1'b0;

        if ((state_q != ST_IDLE) && !start) begin
            state_d = ST_IDLE;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_RESET;
                end
                ST_RESET: begin
                    if (timer_q == TIMER_W'(RST_HOLD - 1)) state_d = ST_WAIT_CAL;
                end
                ST_WAIT_CAL: begin
                    if (cal_done)       state_d = ST_LTR;
                    else if (timed_out) attempt_fail = 1'b1;
                end
                ST_LTR: begin
                    if (status_s.lockedtoref) dwell_d = dwell_q + DWELL_W'(1);
                    if (status_s.lockedtoref && (dwell_q == DWELL_W'(LTR_DWELL - 1)))
                        state_d = ST_LTD;
                    else if (timed_out)
                        attempt_fail = 1'b1;
                end
                ST_LTD: begin
                    if (status_s.lockedtodata && status_s.rx_ready) state_d = ST_UP;
                    else if (timed_out)                              attempt_fail = 1'b1;
                end
                ST_UP: begin
                    if (!status_s.lockedtodata) begin
                        loss_d = loss_q + LOSS_W'(1);
                        if (loss_q == LOSS_W'(LOSS_DEBOUNCE - 1)) attempt_fail = 1'b1;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (attempt_fail) begin
                retry_d = retry_sat_inc(retry_q);
                state_d = (retry_d == RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_RESET;
            end
            if (state_d == ST_UP) retry_d = '0;
        end

        // Timer and per-state counters restart on every state entry.
        if (state_d != state_q) begin
            timer_d = '0;
            dwell_d = '0;
            loss_d  = '0;
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end

        xcvr_reset_d = (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAIL);
        ltr_d        = (state_d == ST_LTR);
        ltd_d        = (state_d == ST_LTD) || (state_d == ST_UP);
        link_up_d    = (state_d == ST_UP);
        link_fail_d  = (state_d == ST_FAIL);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            dwell_q      <= '0;
            loss_q       <= '0;
            retry_q      <= '0;
            xcvr_reset_q <= 1'b1;
            ltr_q        <= 1'b0;
            ltd_q        <= 1'b0;
            link_up_q    <= 1'b0;
            link_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            dwell_q      <= dwell_d;
            loss_q       <= loss_d;
            retry_q      <= retry_d;
            xcvr_reset_q <= xcvr_reset_d;
            ltr_q        <= ltr_d;
            ltd_q        <= ltd_d;
            link_up_q    <= link_up_d;
            link_fail_q  <= link_fail_d;
        end
    end

    assign xcvr_reset        = xcvr_reset_q;
    assign rx_set_locktoref  = ltr_q;
    assign rx_set_locktodata = ltd_q;
    assign link_up           = link_up_q;
    assign link_fail         = link_fail_q;
    assign retry_cnt         = retry_q;
    assign seq_state         = state_q;

`ifdef XCVR_SEQ_STATS_EN
    // Debounced lock-loss events; survives start toggling, cleared only by nRST.
    logic [STAT_W-1:0] loss_cnt_q;
    logic              loss_event;

    assign loss_event = start && (state_q == ST_UP) && !status_s.lockedtodata &&
                        (loss_q == LOSS_W'(LOSS_DEBOUNCE - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            loss_cnt_q <= '0;
        end else if (loss_event && (loss_cnt_q != '1)) begin
            loss_cnt_q <= loss_cnt_q + STAT_W'(1);
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_xcvr_link_sequencer.sv
// Randomised bench for xcvr_link_sequencer against a cycle-level behavioural model
// of the sequencing rules; define XCVR_SEQ_STATS_EN to also check lock_loss_cnt.
module tb_xcvr_link_sequencer;

    localparam int RST_HOLD      = 8;
    localparam int LTR_DWELL     = 50;
    localparam int TIMEOUT       = 1000;
    localparam int MAX_RETRY     = 4;
    localparam int LOSS_DEBOUNCE = 16;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       start = 1'b0;
    logic       tx_ready = 1'b0;
    logic       rx_ready = 1'b0;
    logic       tx_cal_busy = 1'b1;
    logic       rx_cal_busy = 1'b1;
    logic       reconfig_busy = 1'b0;
    logic       rx_is_lockedtoref = 1'b1;
    logic       rx_is_lockedtodata = 1'b0;
    logic       xcvr_reset;
    logic       rx_set_locktoref;
    logic       rx_set_locktodata;
    logic       link_up;
    logic       link_fail;
    logic [3:0] retry_cnt;
    logic [2:0] seq_state;
`ifdef XCVR_SEQ_STATS_EN
    logic [15:0] lock_loss_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural model: phase number (0..6), time in phase, counters, 2-cycle input delay line.
    int         m_st, m_tmr, m_dwell, m_loss, m_retry, m_losses;
    logic [6:0] m_h1, m_h2;

    xcvr_link_sequencer #(
        .RST_HOLD      (RST_HOLD),
        .LTR_DWELL     (LTR_DWELL),
        .TIMEOUT       (TIMEOUT),
        .MAX_RETRY     (MAX_RETRY),
        .LOSS_DEBOUNCE (LOSS_DEBOUNCE)
    ) dut (
        .CLK                (CLK),
        .nRST               (nRST),
        .start              (start),
        .tx_ready           (tx_ready),
        .rx_ready           (rx_ready),
        .tx_cal_busy        (tx_cal_busy),
        .rx_cal_busy        (rx_cal_busy),
        .reconfig_busy      (reconfig_busy),
        .rx_is_lockedtoref  (rx_is_lockedtoref),
        .rx_is_lockedtodata (rx_is_lockedtodata),
        .xcvr_reset         (xcvr_reset),
        .rx_set_locktoref   (rx_set_locktoref),
        .rx_set_locktodata  (rx_set_locktodata),
        .link_up            (link_up),
        .link_fail          (link_fail),
        .retry_cnt          (retry_cnt),
        .seq_state          (seq_state)
`ifdef XCVR_SEQ_STATS_EN
        ,
        .lock_loss_cnt      (lock_loss_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] dut_outs();
        return {xcvr_reset, rx_set_locktoref, rx_set_locktodata, link_up, link_fail,
                retry_cnt, seq_state};
    endfunction

    function automatic logic [11:0] model_outs();
        logic rst_o, ltr_o, ltd_o, up_o, fail_o;
        rst_o  = (m_st == 0) || (m_st == 1) || (m_st == 6);
        ltr_o  = (m_st == 3);
        ltd_o  = (m_st == 4) || (m_st == 5);
        up_o   = (m_st == 5);
        fail_o = (m_st == 6);
        return {rst_o, ltr_o, ltd_o, up_o, fail_o, 4'(m_retry), 3'(m_st)};
    endfunction

    task automatic model_reset();
        m_st = 0; m_tmr = 0; m_dwell = 0; m_loss = 0; m_retry = 0; m_losses = 0;
        m_h1 = '0; m_h2 = '0;
    endtask

    // One clock edge of the sequencing rules, using inputs as they were two edges ago.
    task automatic model_edge();
        logic [6:0] sv;
        logic       txr, rxr, busy, lref, ldat, fail_att;
        int         nxt;
        sv   = m_h2;
        m_h2 = m_h1;
        m_h1 = {rx_is_lockedtodata, rx_is_lockedtoref, reconfig_busy, rx_cal_busy,
                tx_cal_busy, rx_ready, tx_ready};
        txr  = sv[0];
        rxr  = sv[1];
        busy = |sv[4:2];
        lref = sv[5];
        ldat = sv[6];
        nxt  = m_st;
        fail_att = 1'b0;
        if (m_st != 0 && !start) begin
            nxt = 0;
            m_retry = 0;
        end else begin
            case (m_st)
                0: if (start) nxt = 1;
                1: if (m_tmr == RST_HOLD - 1) nxt = 2;
                2: if (!busy && txr) nxt = 3; else fail_att = (m_tmr == TIMEOUT - 1);
                3: begin
                    m_dwell = lref ? m_dwell + 1 : 0;
                    if (m_dwell == LTR_DWELL) nxt = 4; else fail_att = (m_tmr == TIMEOUT - 1);
                end
                4: if (ldat && rxr) nxt = 5; else fail_att = (m_tmr == TIMEOUT - 1);
                5: begin
                    m_loss = ldat ? 0 : m_loss + 1;
                    if (m_loss == LOSS_DEBOUNCE) begin
                        fail_att = 1'b1;
                        if (m_losses < 65535) m_losses++;
                    end
                end
                default: ;
            endcase
            if (fail_att) begin
                m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                nxt = (m_retry == MAX_RETRY) ? 6 : 1;
            end
            if (nxt == 5) m_retry = 0;
        end
        if (nxt != m_st) begin
            m_tmr = 0; m_dwell = 0; m_loss = 0;
        end else begin
            m_tmr++;
        end
        m_st = nxt;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_eq("outs", 32'(dut_outs()), 32'(model_outs()));
`ifdef XCVR_SEQ_STATS_EN
        check_eq("loss_cnt", 32'(lock_loss_cnt), 32'(m_losses));
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_st(input int target, input int budget, input string tag);
        for (int k = 0; k < budget && m_st != target; k++) step();
        check_eq(tag, 32'(seq_state), 32'(target));
    endtask

    // Cycles the DUT spends in state st, counting the cycle already observed.
    task automatic count_state(input int st, input int budget, output int n);
        n = 1;
        for (int k = 0; k < budget && int'(seq_state) == st; k++) begin
            step();
            if (int'(seq_state) == st) n++;
        end
    endtask

    task automatic async_reset();
        #3;
        nRST = 1'b0;
        #1;
        check_eq("async_rst", 32'(dut_outs()), 32'(12'h800));
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_hold", 32'(dut_outs()), 32'(12'h800));
        nRST = 1'b1;
    endtask

    task automatic flip(input int b);
        case (b)
            0: tx_ready = ~tx_ready;
            1: rx_ready = ~rx_ready;
            2: tx_cal_busy = ~tx_cal_busy;
            3: rx_cal_busy = ~rx_cal_busy;
            4: reconfig_busy = ~reconfig_busy;
            5: rx_is_lockedtoref = ~rx_is_lockedtoref;
            default: rx_is_lockedtodata = ~rx_is_lockedtodata;
        endcase
    endtask

    task automatic drop_ltd(input int len);
        rx_is_lockedtodata = 1'b0;
        run(len);
        rx_is_lockedtodata = 1'b1;
    endtask

    initial begin
        int n, n2, total;
        model_reset();
        #12;
        check_eq("reset_vals", 32'(dut_outs()), 32'(12'h800));
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Nominal bring-up.
        start = 1'b1;
        wait_st(1, 5, "enter_reset");
        count_state(1, RST_HOLD + 10, n);
        check_eq("rst_hold_len", 32'(n), 32'(RST_HOLD));
        check_eq("xcvr_reset_low", 32'(xcvr_reset), 32'(0));
        run(int'($urandom_range(120, 80)));
        tx_cal_busy = 1'b0;
        rx_cal_busy = 1'b0;
        tx_ready = 1'b1;
        wait_st(3, 10, "enter_ltr");
        count_state(3, LTR_DWELL + 10, n);
        check_eq("ltr_len", 32'(n), 32'(LTR_DWELL));
        rx_is_lockedtodata = 1'b1;
        rx_ready = 1'b1;
        wait_st(5, 10, "enter_up");
        check_eq("up_link", 32'(link_up), 32'(1));
        check_eq("up_retry", 32'(retry_cnt), 32'(0));

        // Dwell restart after a one-cycle lockedtoref glitch.
        start = 1'b0;
        rx_is_lockedtodata = 1'b0;
        step();
        start = 1'b1;
        wait_st(3, RST_HOLD + 20, "dwell_enter");
        run(30);
        rx_is_lockedtoref = 1'b0;
        step();
        rx_is_lockedtoref = 1'b1;
        count_state(3, 3 * LTR_DWELL, n2);
        total = 32 + n2 - 1;
        check_eq("dwell_restart", 32'(total >= 30 + LTR_DWELL), 32'(1));
        rx_is_lockedtodata = 1'b1;
        wait_st(5, 10, "dwell_up");

        // Lock loss below and at the debounce threshold, three times at threshold.
        drop_ltd(LOSS_DEBOUNCE - 1);
        run(25);
        check_eq("loss15_up", 32'(link_up), 32'(1));
        for (int e = 0; e < 3; e++) begin
            drop_ltd(LOSS_DEBOUNCE);
            wait_st(1, 10, "loss_reset");
            check_eq("loss_retry", 32'(retry_cnt), 32'(1));
            check_eq("loss_linkdn", 32'(link_up), 32'(0));
            wait_st(5, RST_HOLD + LTR_DWELL + 40, "loss_recover");
        end
        start = 1'b0;
        run(3);
        start = 1'b1;
        wait_st(5, RST_HOLD + LTR_DWELL + 40, "restart_up");
`ifdef XCVR_SEQ_STATS_EN
        check_eq("stats_3", 32'(lock_loss_cnt), 32'(3));
`endif

        // Timeout exhaustion.
        start = 1'b0;
        step();
        rx_cal_busy = 1'b1;
        start = 1'b1;
        wait_st(6, MAX_RETRY * (TIMEOUT + RST_HOLD) + 100, "exhaust");
        check_eq("fail_flag", 32'(link_fail), 32'(1));
        check_eq("fail_retry", 32'(retry_cnt), 32'(MAX_RETRY));
        run(20);
        check_eq("fail_stay", 32'(seq_state), 32'(6));
        start = 1'b0;
        step();
        check_eq("fail_idle", 32'(seq_state), 32'(0));
        check_eq("fail_clr", 32'(link_fail), 32'(0));

        // Abort from LTD.
        rx_cal_busy = 1'b0;
        rx_is_lockedtodata = 1'b0;
        rx_ready = 1'b0;
        start = 1'b1;
        wait_st(4, RST_HOLD + LTR_DWELL + 40, "abort_ltd");
        run(3);
        start = 1'b0;
        step();
        check_eq("abort_idle", 32'(seq_state), 32'(0));
        check_eq("abort_rst", 32'(xcvr_reset), 32'(1));
        check_eq("abort_ltd_lo", 32'(rx_set_locktodata), 32'(0));

        // Asynchronous reset in LTR.
        start = 1'b1;
        wait_st(3, RST_HOLD + 40, "nrst_ltr");
        run(10);
        async_reset();

        // Random soak.
        rx_is_lockedtodata = 1'b1;
        rx_ready = 1'b1;
        for (int c = 0; c < 15000; c++) begin
            if ($urandom_range(39, 0) == 0) flip(int'($urandom_range(6, 0)));
            if ($urandom_range(1999, 0) == 0) start = ~start;
            if ($urandom_range(7999, 0) == 0) async_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
